// File: rtl/rx_descramble_lfsr.sv
// Receive descrambler for framed word streams.
// Each frame is HEADER_LEN clear header words followed by N data blocks of
// BLOCK_LEN words. Data words are XORed with an internally generated PN
// sequence (mode 0) or with an externally supplied PN word (mode 1).
// The result is registered, so an output word follows its strobe by one cycle.
module rx_descramble_lfsr #(
    parameter int               DATA_W           = 32,
    parameter int               LFSR_W           = 15,
    parameter logic [LFSR_W-1:0] LFSR_POLY       = 15'h6000,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = 15'h0001,
    parameter int               HEADER_LEN       = 16,
    parameter int               BLOCK_LEN        = 93,
    parameter bit               RESEED_PER_BLOCK = 1'b0
) (
    input  logic              logic_clk_in,
    input  logic              logic_rst_in,
    input  logic              frame_start_in,
    input  logic [7:0]        num_blocks_in,
    input  logic              mode_in,
    input  logic              data_pulse_in,
    input  logic [DATA_W-1:0] data_descramble_in,
    input  logic [DATA_W-1:0] pn_descramble_in,
    output logic              data_descramble_vaild,
    output logic [DATA_W-1:0] data_descramble_out,
    output logic              header_flag_out,
    output logic              frame_done_out,
    output logic              err_stray_out,
    output logic [127:0]      debug_signal
);

    localparam int CNT_W = 16;
    localparam int DBG_W = 2 + CNT_W + 8 + LFSR_W;

    // Last index of the header and of a data block. HEADER_LEN=0 never
    // enters HEADER, so its last index is irrelevant in that case.
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'((HEADER_LEN > 0) ? HEADER_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t              state_reg,     state_next;
    logic [CNT_W-1:0]    word_cnt_reg,  word_cnt_next;
    logic [7:0]          block_cnt_reg, block_cnt_next;
    logic [7:0]          nblk_reg,      nblk_next;
    logic                mode_reg,      mode_next;
    logic [LFSR_W-1:0]   lfsr_reg,      lfsr_next;
    logic                valid_reg,     valid_next;
    logic [DATA_W-1:0]   data_reg,      data_next;
    logic                hdr_reg,       hdr_next;
    logic                done_reg,      done_next;
    logic                err_reg,       err_next;
    logic [DBG_W-1:0]    dbg_reg,       dbg_next;
    logic                dbg_update;

    // Effective context for this cycle: a frame start replaces the current
    // context so a coincident strobe is handled as word 0 of the new frame.
    state_t              eff_state;
    logic [CNT_W-1:0]    eff_word;
    logic [7:0]          eff_block;
    logic [7:0]          eff_nblk;
    logic                eff_mode;
    logic [LFSR_W-1:0]   eff_lfsr;

    // Unrolled LFSR: DATA_W steps per word, first feedback bit lands in the MSB.
    logic [LFSR_W-1:0]   lfsr_chain [DATA_W+1];
    logic [DATA_W-1:0]   pn_int;

    // Select between the registered context and a fresh frame context.
    always_comb begin
        eff_state = state_reg;
        eff_word  = word_cnt_reg;
        eff_block = block_cnt_reg;
        eff_nblk  = nblk_reg;
        eff_mode  = mode_reg;
        eff_lfsr  = lfsr_reg;
        if (frame_start_in) begin
            if (HEADER_LEN > 0)
                eff_state = HEADER;
            else if (num_blocks_in != 8'd0)
                eff_state = DATA;
            else
                eff_state = IDLE;
            eff_word  = '0;
            eff_block = '0;
            eff_nblk  = num_blocks_in;
            eff_mode  = mode_in;
            eff_lfsr  = LFSR_SEED;
        end
    end

    assign lfsr_chain[0] = eff_lfsr;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_lfsr_step
            logic fb;
            assign fb                 = ^(lfsr_chain[gi] & LFSR_POLY);
            assign pn_int[DATA_W-1-gi] = fb;
            assign lfsr_chain[gi+1]   = {lfsr_chain[gi][LFSR_W-2:0], fb};
        end
    endgenerate

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_next     = eff_state;
        word_cnt_next  = eff_word;
        block_cnt_next = eff_block;
        nblk_next      = eff_nblk;
        mode_next      = eff_mode;
        lfsr_next      = eff_lfsr;
        valid_next     = 1'b0;
        done_next      = 1'b0;
        data_next      = data_reg;
        hdr_next       = hdr_reg;
        err_next       = frame_start_in ? 1'b0 : err_reg;
        dbg_update     = frame_start_in;

        // Empty frame: nothing to receive, report completion right away.
        if (frame_start_in && HEADER_LEN == 0 && num_blocks_in == 8'd0)
            done_next = 1'b1;

        if (data_pulse_in) begin
            case (eff_state)
                IDLE: begin
                    // Words outside a frame are dropped; a word that arrives
                    // with the start of an empty frame is not an error.
                    if (!frame_start_in)
                        err_next = 1'b1;
                end
                HEADER: begin
                    valid_next = 1'b1;
                    data_next  = data_descramble_in;
                    hdr_next   = 1'b1;
                    dbg_update = 1'b1;
                    if (eff_word == HDR_LAST) begin
                        word_cnt_next = '0;
                        if (eff_nblk == 8'd0) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                        end
                    end else begin
                        word_cnt_next = eff_word + 1'b1;
                    end
                end
                DATA: begin
                    valid_next = 1'b1;
                    hdr_next   = 1'b0;
                    dbg_update = 1'b1;
                    data_next  = data_descramble_in ^ (eff_mode ? pn_descramble_in : pn_int);
                    if (!eff_mode)
                        lfsr_next = lfsr_chain[DATA_W];
                    if (eff_word == BLK_LAST) begin
                        word_cnt_next  = '0;
                        block_cnt_next = eff_block + 1'b1;
                        // Block-boundary reload wins over the advance above.
                        if (RESEED_PER_BLOCK)
                            lfsr_next = LFSR_SEED;
                        if (eff_block + 8'd1 == eff_nblk) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        word_cnt_next = eff_word + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        dbg_next = dbg_reg;
        if (dbg_update)
            dbg_next = {state_next, word_cnt_next, block_cnt_next, lfsr_next};
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= '0;
            block_cnt_reg <= '0;
            nblk_reg      <= '0;
            mode_reg      <= 1'b0;
            lfsr_reg      <= LFSR_SEED;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            hdr_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            dbg_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            block_cnt_reg <= block_cnt_next;
            nblk_reg      <= nblk_next;
            mode_reg      <= mode_next;
            lfsr_reg      <= lfsr_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
            hdr_reg       <= hdr_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            dbg_reg       <= dbg_next;
        end
    end

    assign data_descramble_vaild = valid_reg;
    assign data_descramble_out   = data_reg;
    assign header_flag_out       = hdr_reg;
    assign frame_done_out        = done_reg;
    assign err_stray_out         = err_reg;
    assign debug_signal          = {{(128-DBG_W){1'b0}}, dbg_reg};

endmodule

// File: tb/tb_rx_descramble_lfsr.sv
// Bench for rx_descramble_lfsr: two instances (no reseed / per-block reseed)
// share one stimulus stream. A frame-position model predicts every output.
module tb_rx_descramble_lfsr;

    localparam int         DW   = 4;
    localparam int         LW   = 3;
    localparam int         HL   = 2;
    localparam int         BL   = 2;
    localparam logic [2:0] POLY = 3'b110;
    localparam logic [2:0] SEED = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs = 1'b0, m = 1'b0, p = 1'b0;
    logic [7:0] n = 8'd0;
    logic [3:0] din = 4'h0, pnin = 4'h0;

    logic         valid_o [2];
    logic [3:0]   data_o  [2];
    logic         hdr_o   [2];
    logic         done_o  [2];
    logic         err_o   [2];
    logic [127:0] dbg_o   [2];

    int total = 0;
    int bad   = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            rx_descramble_lfsr #(
                .DATA_W(DW), .LFSR_W(LW), .LFSR_POLY(POLY), .LFSR_SEED(SEED),
                .HEADER_LEN(HL), .BLOCK_LEN(BL), .RESEED_PER_BLOCK(gi == 1)
            ) u_dut (
                .logic_clk_in          (clk),
                .logic_rst_in          (rst),
                .frame_start_in        (fs),
                .num_blocks_in         (n),
                .mode_in               (m),
                .data_pulse_in         (p),
                .data_descramble_in    (din),
                .pn_descramble_in      (pnin),
                .data_descramble_vaild (valid_o[gi]),
                .data_descramble_out   (data_o[gi]),
                .header_flag_out       (hdr_o[gi]),
                .frame_done_out        (done_o[gi]),
                .err_stray_out         (err_o[gi]),
                .debug_signal          (dbg_o[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // ---------------- model ----------------
    bit         m_active [2];
    int         m_pos    [2];
    int         m_nblk   [2];
    bit         m_mode   [2];
    bit         m1_seen  [2];
    logic       e_valid  [2];
    logic [3:0] e_data   [2];
    logic       e_hdr    [2];
    logic       e_done   [2];
    logic       e_err    [2];

    // PN word whose first bit is the offset-th bit of the sequence from SEED.
    function automatic logic [3:0] pn_word(input int offset);
        logic [2:0] s;
        logic       f;
        logic [3:0] w;
        s = SEED;
        w = 4'h0;
        for (int i = 0; i < offset + DW; i++) begin
            f = ^(s & POLY);
            s = {s[1:0], f};
            if (i >= offset) w[DW-1-(i-offset)] = f;
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 2; r++) begin
            m_active[r] = 1'b0; m_pos[r] = 0; m_nblk[r] = 0; m_mode[r] = 1'b0;
            m1_seen[r] = 1'b0;
            e_valid[r] = 1'b0; e_data[r] = 4'h0; e_hdr[r] = 1'b0;
            e_done[r] = 1'b0; e_err[r] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs applied for it.
    task automatic model_step();
        int len, d, off;
        for (int r = 0; r < 2; r++) begin
            e_valid[r] = 1'b0;
            e_done[r]  = 1'b0;
            if (fs) begin
                m_nblk[r]   = int'(n);
                m_mode[r]   = m;
                m1_seen[r]  = m;
                m_pos[r]    = 0;
                e_err[r]    = 1'b0;
                m_active[r] = (HL + int'(n) * BL) > 0;
                if (!m_active[r]) e_done[r] = 1'b1;
            end
            if (p) begin
                if (m_active[r]) begin
                    len = HL + m_nblk[r] * BL;
                    e_valid[r] = 1'b1;
                    if (m_pos[r] < HL) begin
                        e_data[r] = din;
                        e_hdr[r]  = 1'b1;
                    end else begin
                        d   = m_pos[r] - HL;
                        off = (r == 1) ? (d % BL) * DW : d * DW;
                        e_data[r] = din ^ (m_mode[r] ? pnin : pn_word(off));
                        e_hdr[r]  = 1'b0;
                    end
                    if (m_pos[r] == len - 1) begin
                        e_done[r]   = 1'b1;
                        m_active[r] = 1'b0;
                    end
                    m_pos[r]++;
                end else if (!fs) begin
                    e_err[r] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input int r, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, r, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int r = 0; r < 2; r++) begin
            check("valid", r, 128'(valid_o[r]), 128'(e_valid[r]));
            check("data",  r, 128'(data_o[r]),  128'(e_data[r]));
            check("hdr",   r, 128'(hdr_o[r]),   128'(e_hdr[r]));
            check("done",  r, 128'(done_o[r]),  128'(e_done[r]));
            check("err",   r, 128'(err_o[r]),   128'(e_err[r]));
            if (m1_seen[r])
                check("ext_lfsr_hold", r, 128'(dbg_o[r][LW-1:0]), 128'(SEED));
        end
    end

    // One clock of stimulus; returns at the following falling edge.
    task automatic step(input logic f_s, input logic [7:0] nb, input logic md,
                        input logic pl, input logic [3:0] d, input logic [3:0] pn);
        fs = f_s; n = nb; m = md; p = pl; din = d; pnin = pn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        $display("txn t=%0t fs=%0b n=%0d mode=%0b pulse=%0b in=%h pn=%h -> v=%0b/%0b out=%h/%h hdr=%0b done=%0b/%0b err=%0b",
                 $time, f_s, nb, md, pl, d, pn, valid_o[0], valid_o[1], data_o[0], data_o[1],
                 hdr_o[0], done_o[0], done_o[1], err_o[0]);
        fs = 1'b0; p = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic strobe(input logic [3:0] d);
        step(1'b0, 8'd0, 1'b0, 1'b1, d, 4'h0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic hit_reset();
        #2 rst = 1'b1;
        #1;
        for (int r = 0; r < 2; r++) begin
            check("rst_valid", r, 128'(valid_o[r]), 128'(0));
            check("rst_data",  r, 128'(data_o[r]),  128'(0));
            check("rst_hdr",   r, 128'(hdr_o[r]),   128'(0));
            check("rst_dbg",   r, dbg_o[r],         128'(0));
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_dbg", 0, dbg_o[0], 128'(0));

        // Literal pins on the PN model.
        check("pn_off0", 0, 128'(pn_word(0)), 128'(4'b0111));
        check("pn_off4", 0, 128'(pn_word(4)), 128'(4'b0010));
        check("pn_off8", 0, 128'(pn_word(8)), 128'(4'b1110));

        // LFSR sequence.
        step(1'b1, 8'd1, 1'b0, 1'b0, 4'h0, 4'h0);
        strobe(4'h0); strobe(4'h0);
        strobe(4'h0); check("t1_w0", 0, 128'(data_o[0]), 128'(4'h7));
        strobe(4'h0); check("t1_w1", 0, 128'(data_o[0]), 128'(4'h2));
        check("t1_done", 0, 128'(done_o[0]), 128'(1));
        idle(2);

        // Header pass-through and XOR.
        step(1'b1, 8'd1, 1'b0, 1'b0, 4'h0, 4'h0);
        strobe(4'hA); check("t2_h0", 0, 128'(data_o[0]), 128'(4'hA));
        strobe(4'h5);
        strobe(4'hF); check("t2_d0", 0, 128'(data_o[0]), 128'(4'h8));
        strobe(4'hF); check("t2_d1", 0, 128'(data_o[0]), 128'(4'hD));
        idle(1);

        // Two blocks back-to-back; instance 1 reseeds per block.
        step(1'b1, 8'd2, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) strobe(4'h0);
        check("t3_rs_b1w0", 1, 128'(data_o[1]), 128'(4'h7));
        check("t3_nr_b1w0", 0, 128'(data_o[0]), 128'(4'hE));
        strobe(4'h0);
        check("t3_rs_b1w1", 1, 128'(data_o[1]), 128'(4'h2));
        check("t3_nr_b1w1", 0, 128'(data_o[0]), 128'(4'h5));
        check("t3_done",    1, 128'(done_o[1]), 128'(1));
        idle(1);

        // External PN mode.
        step(1'b1, 8'd1, 1'b1, 1'b0, 4'h0, 4'h5);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'h3, 4'h5);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'h3, 4'h5);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'h6, 4'h5); check("t4_d0", 0, 128'(data_o[0]), 128'(4'h3));
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'h6, 4'h5); check("t4_d1", 0, 128'(data_o[0]), 128'(4'h3));
        check("t4_lfsr", 0, 128'(dbg_o[0][LW-1:0]), 128'(SEED));
        idle(1);

        // Abort and restart with a coincident strobe.
        step(1'b1, 8'd1, 1'b0, 1'b0, 4'h0, 4'h0);
        strobe(4'h0); strobe(4'h0); strobe(4'hF);
        step(1'b1, 8'd1, 1'b0, 1'b1, 4'h9, 4'h0);
        check("t5_restart_hdr", 0, 128'(hdr_o[0]), 128'(1));
        check("t5_restart_out", 0, 128'(data_o[0]), 128'(4'h9));
        strobe(4'h0);
        strobe(4'h0); check("t5_d0", 0, 128'(data_o[0]), 128'(4'h7));
        strobe(4'h0); check("t5_done", 0, 128'(done_o[0]), 128'(1));
        idle(1);

        // Stray strobe, header-only frame, then reset mid-DATA.
        strobe(4'hC);
        check("t6_stray_valid", 0, 128'(valid_o[0]), 128'(0));
        check("t6_stray_err",   0, 128'(err_o[0]),   128'(1));
        idle(2);
        step(1'b1, 8'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("t6_err_clear", 0, 128'(err_o[0]), 128'(0));
        strobe(4'hA);
        strobe(4'hB); check("t6_hdr_only_done", 0, 128'(done_o[0]), 128'(1));
        step(1'b1, 8'd2, 1'b0, 1'b0, 4'h0, 4'h0);
        strobe(4'h1); strobe(4'h2); strobe(4'hF);
        hit_reset();
        idle(2);

        // Recovery after reset.
        step(1'b1, 8'd1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) strobe(4'h0);
        check("t7_done", 0, 128'(done_o[0]), 128'(1));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
